pkt_rr_arbiter: RTL and testbench

Packet-level round-robin arbiter in front of the data-packer FIFO write port. It shares the single FIFO write port between `NumReq` valid/ready/last packet sources. Grant is held for a whole packet, so beats from different sources never interleave and the FIFO's last-tracking stays coherent. It sits between the upstream packet sources and the FIFO's writeData/writeDataValid/writeDataReady/writeDataLast port.

---
 rtl/pkt_arb_pkg.sv | 18 +
 rtl/rr_pick.sv | 35 +++
 rtl/pkt_rr_arbiter.sv | 165 ++++++++++++++++
 tb/tb_pkt_rr_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_arb_pkg.sv
// Shared definitions for the packet-level round-robin arbiter.
// Holds the arbiter state enum, the requester-count ceiling and the
// pointer-width helper used by pkt_rr_arbiter and rr_pick.
package pkt_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int NUM_REQ_MAX = 16;

    // Width of an index into NumReq requesters; never narrower than one bit.
    function automatic int ptr_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: returns the first requester at or
// after ptr+1 (wrapping modulo NumReq) as a one-hot vector plus its index.
module rr_pick
    import pkt_arb_pkg::*;
#(
    parameter  int NumReq = 4,
    localparam int PtrW   = ptr_width(NumReq)
) (
    input  logic [NumReq-1:0] req,
    input  logic [PtrW-1:0]   ptr,
    output logic [NumReq-1:0] winner,
    output logic [PtrW-1:0]   winner_idx,
    output logic              any_req
);

    int pos;

    // Scan from the farthest offset down to ptr+1 so the nearest requester overwrites the rest.
    always_comb begin
        winner     = '0;
        winner_idx = '0;
        pos        = 0;
        for (int k = NumReq; k >= 1; k--) begin
            pos = (int'(ptr) + k) % NumReq;
            if (req[pos]) begin
                winner      = '0;
                winner[pos] = 1'b1;
                winner_idx  = PtrW'(pos);
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/pkt_rr_arbiter.sv
// Packet-level round-robin arbiter in front of the FIFO write port.
// Grant is held from the first beat to the last beat of a packet so beats
// from different sources never interleave.
// Optional feature macro: PKT_ARB_MAXLEN_EN -- enforces a MaxBeats packet
// length, forcing out_last on the limit beat and pulsing trunc_err.
module pkt_rr_arbiter
    import pkt_arb_pkg::*;
#(
    parameter int NumReq    = 4,
    parameter int DataWidth = 32,
    parameter int MaxBeats  = 256
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NumReq-1:0]           req_valid,
    input  logic [NumReq*DataWidth-1:0] req_data,
    input  logic [NumReq-1:0]           req_last,
    output logic [NumReq-1:0]           req_ready,
    output logic [DataWidth-1:0]        out_data,
    output logic                        out_valid,
    output logic                        out_last,
    input  logic                        out_ready,
    output logic [NumReq-1:0]           grant,
    output logic                        busy,
    output logic                        trunc_err
);

    localparam int PtrW = ptr_width(NumReq);

    arb_state_e        state_q, state_d;
    logic [NumReq-1:0] grant_q, grant_d;
    logic [PtrW-1:0]   ptr_q, ptr_d;
    logic [PtrW-1:0]   gidx_q, gidx_d;

    logic [NumReq-1:0] pick_onehot;
    logic [PtrW-1:0]   pick_idx;
    logic              pick_any;

    logic [DataWidth-1:0] data_terms [NumReq];
    logic                 src_last;
    logic                 xfer;

    rr_pick #(
        .NumReq (NumReq)
    ) u_rr_pick (
        .req        (req_valid),
        .ptr        (ptr_q),
        .winner     (pick_onehot),
        .winner_idx (pick_idx),
        .any_req    (pick_any)
    );

    // Requester counts above the package ceiling are outside the supported range.
    if (NumReq > NUM_REQ_MAX) begin : g_numreq_above_max
    end

    // One-hot AND-OR mux: with no grant held every term is zero, so out_data idles at 0.
    for (genvar gi = 0; gi < NumReq; gi++) begin : g_data_mux
        assign data_terms[gi] = grant_q[gi] ? req_data[gi*DataWidth +: DataWidth] : '0;
    end

    // OR together the masked per-source data words.
    always_comb begin
        out_data = '0;
        for (int i = 0; i < NumReq; i++) begin
            out_data = out_data | data_terms[i];
        end
    end

    assign out_valid = |(grant_q & req_valid);
    assign src_last  = |(grant_q & req_last);
    assign req_ready = grant_q & {NumReq{out_ready}};
    assign xfer      = out_valid & out_ready;
    assign grant     = grant_q;
    assign busy      = (state_q == LOCKED);

`ifdef PKT_ARB_MAXLEN_EN
    localparam int CntW = $clog2(MaxBeats + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            trunc_q, trunc_d;
    logic            at_limit;

    // cnt_q holds the number of beats already sent, so the limit beat is cnt_q == MaxBeats-1.
    assign at_limit  = (cnt_q == CntW'(MaxBeats - 1));
    assign out_last  = src_last | (out_valid & at_limit);
    assign trunc_err = trunc_q;

    // Beat counter restarts on every new grant; truncation flagged when the limit beat had no real last.
    always_comb begin
        cnt_d   = cnt_q;
        trunc_d = 1'b0;
        if (state_q == IDLE) begin
            if (pick_any) begin
                cnt_d = '0;
            end
        end else if (xfer) begin
            cnt_d   = cnt_q + CntW'(1);
            trunc_d = at_limit & ~src_last;
        end
    end

    // Counter and truncation pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            trunc_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            trunc_q <= trunc_d;
        end
    end
`else
    assign out_last  = src_last;
    assign trunc_err = 1'b0;

    // MaxBeats has no effect when the length limit is not built in.
    if (MaxBeats < 1) begin : g_maxbeats_unused
    end
`endif

    // Next-state logic: lock onto the round-robin winner, release after the last beat.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_onehot;
                    gidx_d  = pick_idx;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (xfer && out_last) begin
                    grant_d = '0;
                    ptr_d   = gidx_q;
                    state_d = IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // FSM registers; ptr resets to the top index so source 0 wins first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= PtrW'(NumReq - 1);
            gidx_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
        end
    end

endmodule

// File: tb/tb_pkt_rr_arbiter.sv
// Scoreboard testbench for pkt_rr_arbiter (4 requesters, 32-bit beats).
// Source BFMs present queued beats; expected output beats are queued at
// stimulus time and checked by an independent monitor.
module tb_pkt_rr_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
`ifdef PKT_ARB_MAXLEN_EN
    localparam int MB = 4;
`else
    localparam int MB = 256;
`endif

    typedef struct packed {
        logic [1:0]  src;
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_last;
    logic [NR-1:0]    req_ready;
    logic [DW-1:0]    out_data;
    logic             out_valid;
    logic             out_last;
    logic             out_ready;
    logic [NR-1:0]    grant;
    logic             busy;
    logic             trunc_err;

    logic [32:0]   srcq [NR][$];
    exp_t          sb[$];
    logic [NR-1:0] hold;
    logic [NR-1:0] fire;
    logic [3:0]    glog[$];
    int            n_cmp = 0;
    int            n_err = 0;
    int            trunc_cnt = 0;
    int            trunc_total = 0;

    pkt_rr_arbiter #(
        .NumReq    (NR),
        .DataWidth (DW),
        .MaxBeats  (MB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .grant     (grant),
        .busy      (busy),
        .trunc_err (trunc_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Queue a packet on a source and its expected beats on the scoreboard.
    task automatic send(input int src, input int n, input logic [31:0] base);
        exp_t e;
        for (int b = 0; b < n; b++) begin
            srcq[src].push_back({(b == n - 1), base + 32'(b)});
            e.src  = 2'(src);
            e.data = base + 32'(b);
            e.last = (b == n - 1);
            sb.push_back(e);
        end
    endtask

    task automatic wait_grant(input string name, input logic [3:0] exp_g);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (grant == '0 && n < 20);
        chk(name, 64'(grant), 64'(exp_g));
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(sb.size()), 64'd0);
    endtask

    task automatic flush_all();
        for (int i = 0; i < NR; i++) srcq[i].delete();
        sb.delete();
    endtask

    // Source BFMs: drop a beat after it was accepted, present the next queue head.
    initial begin
        logic [32:0] h;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        fire      = '0;
        forever begin
            @(negedge clk);
            fire = req_valid & req_ready;
            @(posedge clk);
            #2;
            for (int i = 0; i < NR; i++) begin
                if (fire[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
                if (srcq[i].size() > 0 && !hold[i]) begin
                    h = srcq[i][0];
                    req_valid[i]            = 1'b1;
                    req_data[i*DW +: DW]    = h[31:0];
                    req_last[i]             = h[32];
                end else begin
                    req_valid[i]            = 1'b0;
                    req_data[i*DW +: DW]    = '0;
                    req_last[i]             = 1'b0;
                end
            end
        end
    end

    // Monitor: every accepted output beat must match the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (trunc_err) begin
                    trunc_cnt++;
                    trunc_total++;
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_beat: got data %h grant %b expected no beat", out_data, grant);
                    end else begin
                        e = sb.pop_front();
                        $display("beat src=%0d data=%h last=%0d grant=%b", e.src, out_data, out_last, grant);
                        chk("beat_data", 64'(out_data), 64'(e.data));
                        chk("beat_last", 64'(out_last), 64'(e.last));
                        chk("beat_grant", 64'(grant), 64'(1) << e.src);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int f;
        logic [3:0] eg;
        hold      = '0;
        out_ready = 1'b1;
        reset     = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_trunc", 64'(trunc_err), 64'd0);

        // Single source, 3-beat packet
        @(posedge clk); #1;
        send(1, 3, 32'h1000_00A0);
        @(negedge clk);
        chk("t1_grant_pre", 64'(grant), 64'd0);
        @(negedge clk);
        chk("t1_grant", 64'(grant), 64'b0010);
        chk("t1_busy", 64'(busy), 64'd1);
        repeat (2) @(negedge clk);
        chk("t1_last_beat", 64'(out_last), 64'd1);
        @(negedge clk);
        chk("t1_grant_end", 64'(grant), 64'd0);
        chk("t1_busy_end", 64'(busy), 64'd0);
        wait_drain("t1_drain");

        // All sources streaming 2-beat packets from a fresh reset
        #3 reset = 1'b1;
        flush_all();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        for (int p = 0; p < 2; p++)
            for (int s = 0; s < NR; s++)
                send(s, 2, 32'h2000_0000 + 32'(s * 16 + p * 4));
        glog.delete();
        repeat (40) begin
            @(negedge clk);
            glog.push_back(grant);
        end
        f = 0;
        while (f < glog.size() - 1 && glog[f] == '0) f++;
        for (int k = 0; k < 15; k++) begin
            eg = (k % 3 == 2) ? 4'b0000 : 4'(4'b0001 << ((k / 3) % 4));
            chk($sformatf("t2_grant_seq%0d", k), 64'(glog[f + k]), 64'(eg));
        end
        wait_drain("t2_drain");

        // Backpressure after beat 1 of source 0
        @(posedge clk); #1;
        send(0, 3, 32'h3000_0000);
        wait_grant("t3_grant", 4'b0001);
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t3_hold_data", 64'(out_data), 64'h3000_0001);
            chk("t3_hold_ready", 64'(req_ready), 64'd0);
            chk("t3_hold_grant", 64'(grant), 64'b0001);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("t3_resume_ready", 64'(req_ready), 64'b0001);
        chk("t3_resume_data", 64'(out_data), 64'h3000_0001);
        wait_drain("t3_drain");

        // Source 2 stalls mid-packet while source 1 waits
        @(posedge clk); #1;
        send(2, 3, 32'h4000_0020);
        wait_grant("t4_grant", 4'b0100);
        @(posedge clk); #1;
        hold[2] = 1'b1;
        send(1, 1, 32'h4000_0010);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("t4_stall_grant", 64'(grant), 64'b0100);
            chk("t4_stall_valid", 64'(out_valid), 64'd0);
            @(posedge clk); #1;
        end
        hold[2] = 1'b0;
        wait_drain("t4_drain");

        // Asynchronous reset mid-packet
        @(posedge clk); #1;
        send(0, 4, 32'h6000_0000);
        wait_grant("t6_grant", 4'b0001);
        repeat (2) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_grant", 64'(grant), 64'd0);
        chk("t6_rst_valid", 64'(out_valid), 64'd0);
        chk("t6_rst_ready", 64'(req_ready), 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        flush_all();
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        send(0, 1, 32'h6100_0000);
        send(2, 1, 32'h6100_0002);
        wait_grant("t6_first_win", 4'b0001);
        wait_drain("t6_drain");

`ifdef PKT_ARB_MAXLEN_EN
        // 6-beat packet against a 4-beat limit
        begin
            exp_t e;
            @(posedge clk); #1;
            trunc_cnt = 0;
            for (int b = 0; b < 6; b++) begin
                srcq[3].push_back({(b == 5), 32'h5000_0000 + 32'(b)});
                e.src  = 2'd3;
                e.data = 32'h5000_0000 + 32'(b);
                e.last = (b == 3) || (b == 5);
                sb.push_back(e);
            end
            wait_drain("t5_drain");
            repeat (2) @(negedge clk);
            chk("t5_trunc_pulses", 64'(trunc_cnt), 64'd1);
        end
`else
        chk("trunc_never", 64'(trunc_total), 64'd0);
`endif

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
